// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, bit_tick and mid-bit tick for UART timing.
// Optional macro BAUD_FRAC_EN adds the fractional accumulator; without it the period is the integer divisor.
module baud_gen_frac #(
    parameter int unsigned DVSR_W        = 16,
    parameter int unsigned FRAC_W        = 4,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DVSR_INT_RST  = 325,
    parameter int unsigned DVSR_FRAC_RST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [DVSR_W-1:0] dvsr_int,
    input  logic [FRAC_W-1:0] dvsr_frac,
    input  logic              load,
    output logic              tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              cfg_err
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DVSR_W-1:0] cnt;
    logic [DVSR_W-1:0] d_act;
    logic [DVSR_W-1:0] d_shd;
    logic [OS_W-1:0]   os_cnt;
    logic              pend;
    logic [DVSR_W:0]   period_m1;
    logic              stalled;
    logic              boundary;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] f_act;
    logic [FRAC_W-1:0] f_shd;
    logic              carry;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum   = {1'b0, acc} + {1'b0, f_act};
    // One bit wider than the divisor so D = 2^DVSR_W-1 plus carry cannot wrap.
    assign period_m1 = {1'b0, d_act} + (DVSR_W+1)'(carry) - (DVSR_W+1)'(1);
`else
    logic frac_unused;

    assign frac_unused = ^{dvsr_frac, FRAC_W'(DVSR_FRAC_RST)};
    assign period_m1   = {1'b0, d_act} - (DVSR_W+1)'(1);
`endif

    assign stalled  = (d_act == '0);
    assign boundary = en && !restart && !stalled && ({1'b0, cnt} == period_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            os_cnt   <= '0;
            pend     <= 1'b0;
            d_act    <= DVSR_W'(DVSR_INT_RST);
            d_shd    <= DVSR_W'(DVSR_INT_RST);
            tick     <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc      <= '0;
            carry    <= 1'b0;
            f_act    <= FRAC_W'(DVSR_FRAC_RST);
            f_shd    <= FRAC_W'(DVSR_FRAC_RST);
`endif
        end else begin
            cfg_err <= stalled;
            if (restart) begin
                cnt      <= '0;
                os_cnt   <= '0;
                tick     <= 1'b0;
                bit_tick <= 1'b0;
                mid_tick <= 1'b0;
`ifdef BAUD_FRAC_EN
                acc      <= '0;
                carry    <= 1'b0;
`endif
                // A load in the restart cycle is newer than any pending shadow.
                if (load) begin
                    d_act <= dvsr_int;
                    d_shd <= dvsr_int;
                    pend  <= 1'b0;
`ifdef BAUD_FRAC_EN
                    f_act <= dvsr_frac;
                    f_shd <= dvsr_frac;
`endif
                end else if (pend) begin
                    d_act <= d_shd;
                    pend  <= 1'b0;
`ifdef BAUD_FRAC_EN
                    f_act <= f_shd;
`endif
                end
            end else begin
                tick     <= boundary;
                bit_tick <= boundary && (os_cnt == OS_LAST);
                mid_tick <= boundary && (os_cnt == OS_MID);

                if (boundary) begin
                    cnt    <= '0;
                    os_cnt <= os_cnt + 1'b1;
`ifdef BAUD_FRAC_EN
                    {carry, acc} <= acc_sum;
`endif
                end else if (en && stalled) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end

                // Shadow is applied at a boundary, or right away when no boundary can come.
                if (load && boundary) begin
                    d_act <= dvsr_int;
                    d_shd <= dvsr_int;
                    pend  <= 1'b0;
`ifdef BAUD_FRAC_EN
                    f_act <= dvsr_frac;
                    f_shd <= dvsr_frac;
`endif
                end else if (load) begin
                    d_shd <= dvsr_int;
                    pend  <= 1'b1;
`ifdef BAUD_FRAC_EN
                    f_shd <= dvsr_frac;
`endif
                end else if (pend && (boundary || !en || stalled)) begin
                    d_act <= d_shd;
                    pend  <= 1'b0;
`ifdef BAUD_FRAC_EN
                    f_act <= f_shd;
`endif
                end
            end
        end
    end
endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator with an oversampling bit-phase counter, replacing the fixed integer divider for UART TX/RX timing. It emits a one-cycle oversample `tick`, a `bit_tick` every OVERSAMPLE ticks, and a `mid_tick` at bit centre for the receiver sampler. The divisor is integer plus fraction, reloaded through a shadow register at period boundaries. Sits between the system clock domain and `uart_tx`/`uart_rx`.

## Interface
- DVSR_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor; fraction = dvsr_frac / 2^FRAC_W.
- OVERSAMPLE, 16: ticks per bit; power of two, ≥ 2.
- DVSR_INT_RST, 325: active integer divisor after reset (50 MHz / (9600·16)).
- DVSR_FRAC_RST, 8: active fractional divisor after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; low freezes all counters.
- restart  in  1  synchronous phase realign (RX start-bit edge).
- dvsr_int  in  DVSR_W  new integer divisor D.
- dvsr_frac  in  FRAC_W  new fractional divisor F.
- load  in  1  one-cycle strobe: capture dvsr_int/dvsr_frac into shadow.
- tick  out  1  oversample tick, one-cycle pulse, registered.
- bit_tick  out  1  high with every OVERSAMPLE-th tick.
- mid_tick  out  1  high with the (OVERSAMPLE/2)-th tick of each bit.
- cfg_err  out  1  active D == 0; generator stalled.

## Operation
- State: cnt (DVSR_W), acc (FRAC_W), carry (1), os_cnt (log2 OVERSAMPLE), active D/F, shadow D/F, pend flag.
- Period length P = D + carry; carry is the carry-out of the previous boundary's acc update; first period after reset/restart has carry = 0.
- Each enabled cycle: if cnt == P-1 → boundary: cnt ← 0, tick ← 1, {carry, acc} ← acc + F; else cnt ← cnt+1, tick ← 0.
- At boundary, os_cnt ← os_cnt+1 (wraps at OVERSAMPLE); bit_tick = tick ∧ old os_cnt == OVERSAMPLE-1; mid_tick = tick ∧ old os_cnt == OVERSAMPLE/2-1.
- load: shadow ← inputs, pend ← 1. At next boundary (or while en = 0, next cycle) active ← shadow, pend ← 0; new values govern the following period. load and boundary in same cycle: the load values apply to the next period. Second load before apply: latest wins.
- en = 0: cnt, acc, carry, os_cnt held; tick/bit_tick/mid_tick 0.
- restart (priority over en and boundary): cnt, acc, carry, os_cnt ← 0; pending shadow applied immediately; all tick outputs 0 that cycle.
- D == 0: cfg_err = 1, cnt held at 0, no ticks. D == 1, carry = 0: tick every cycle.
- cnt compares use DVSR_W+1 bits so D = 2^DVSR_W-1 with carry does not wrap.

## Timing
- Reset: tick, bit_tick, mid_tick, cfg_err, cnt, acc, carry, os_cnt, pend = 0; active = DVSR_INT_RST/DVSR_FRAC_RST; shadow = same.
- First tick on the D-th rising edge after rst deassertion (en = 1); subsequent spacing = P.
- Outputs registered; zero combinational paths input→output.
- Reset asserted mid-period: all state returns to reset values asynchronously; pending load discarded.
- cfg_err updates the cycle after active D changes.

## Configuration
- BAUD_FRAC_EN defined: fractional accumulator present as above.
- Undefined: acc/carry removed, dvsr_frac and DVSR_FRAC_RST ignored, P = D always; all other behaviour identical.

## Test plan
- D=4, F=0, OVERSAMPLE=16, en=1 after reset → tick on edges 4, 8, 12…; bit_tick on 16th tick (edge 64); mid_tick on 8th tick (edge 32).
- D=4, F=8, FRAC_W=4 (BAUD_FRAC_EN) → periods 4,4,5,4,5,…; 32 ticks span exactly 4·32+15 = 143 cycles.
- load D=6 mid-period of D=4 → current period completes at 4, next period 6; load coincident with boundary → next period 6.
- restart asserted with os_cnt=9 → all outputs 0 that cycle, next tick D cycles later, mid_tick on 8th tick after restart.
- load D=0 → cfg_err=1, no ticks for 100 cycles; load D=3 → cfg_err=0, ticks every 3.
- en low for 10 cycles mid-period → tick delayed exactly 10 cycles; async rst mid-period → all outputs 0 immediately, defaults restored.
